// File: rtl/adc_capture_ctrl.sv
// Write-side sequencer for the ADC sample FIFO: arm, wait for a trigger edge,
// then write a programmed number of (optionally decimated) samples.
module adc_capture_ctrl #(
    parameter int DATA_W = 14,
    parameter int LEN_W  = 16,
    parameter int DEC_W  = 4
) (
    input  logic              clk_a,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [DEC_W-1:0]  decim,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       drop_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               trig_d;
    logic [LEN_W-1:0]   len_q;
    logic [DEC_W-1:0]   decim_q;
    logic [LEN_W-1:0]   sample_cnt;
    logic [DEC_W-1:0]   dec_cnt;

    logic               load, start, accept, drop, finish, advance;
    logic               eligible;
    logic [LEN_W-1:0]   cnt_inc;

    assign eligible = (dec_cnt == '0);
    assign cnt_inc  = sample_cnt + LEN_W'(1);
    assign advance  = (state_q == CAPTURE) && adc_valid && !abort;

    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves a latch.
        state_d = state_q;
        load    = 1'b0;
        start   = 1'b0;
        accept  = 1'b0;
        drop    = 1'b0;
        finish  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm && frame_len != '0) begin
                        load    = 1'b1;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (trig && !trig_d) begin
                        start   = 1'b1;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (adc_valid && eligible) begin
                        if (fifo_full) begin
                            drop = 1'b1;
                        end else begin
                            accept = 1'b1;
                            if (cnt_inc == len_q) begin
                                finish  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: synchronous reset, and all state updates use non-blocking assignments.
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q      <= IDLE;
            trig_d       <= 1'b0;
            len_q        <= '0;
            decim_q      <= '0;
            sample_cnt   <= '0;
            dec_cnt      <= '0;
            drop_cnt     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            done         <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_d     <= trig;
            fifo_wr_en <= accept;
            done       <= finish;
            if (accept) begin
                fifo_wr_data <= adc_data;
                sample_cnt   <= cnt_inc;
            end
            if (load) begin
                len_q    <= frame_len;
                decim_q  <= decim;
                drop_cnt <= '0;
            end else if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            // Decimation phase advances on every valid sample, kept or not.
            if (start) begin
                sample_cnt <= '0;
                dec_cnt    <= '0;
            end else if (advance) begin
                dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DEC_W'(1);
            end
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a small model pushes expected writes
// to a queue, and a monitor pops and compares them as the FIFO is written.
module tb_adc_capture_ctrl;
    localparam int DATA_W = 14;
    localparam int LEN_W  = 16;
    localparam int DEC_W  = 4;

    logic              clk_a = 1'b0;
    logic              rst, arm, abort, trig, adc_valid, fifo_full;
    logic [LEN_W-1:0]  frame_len;
    logic [DEC_W-1:0]  decim;
    logic [DATA_W-1:0] adc_data;
    logic              fifo_wr_en, busy, done;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [15:0]       drop_cnt;
    logic [1:0]        state;

    adc_capture_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DEC_W(DEC_W)) dut (
        .clk_a(clk_a), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
        .frame_len(frame_len), .decim(decim), .adc_data(adc_data),
        .adc_valid(adc_valid), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .busy(busy), .done(done),
        .drop_cnt(drop_cnt), .state(state)
    );

    always #5 clk_a = ~clk_a;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] popped;
    int extra_writes = 0;
    int done_cnt = 0;
    int exp_done = 0;

    // Reference model state
    bit m_active = 1'b0;
    int m_dec, m_cnt, m_len, m_decim;
    int m_drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic full);
        adc_valid = 1'b1;
        adc_data  = d;
        fifo_full = full;
        if (m_active) begin
            if (m_dec == 0) begin
                if (full) begin
                    if (m_drops < 65535) m_drops++;
                end else begin
                    exp_q.push_back(d);
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_active = 1'b0;
                        exp_done++;
                    end
                end
            end
            m_dec = (m_dec == m_decim) ? 0 : m_dec + 1;
        end
        tick();
        adc_valid = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic do_arm(input int len, input int dec);
        frame_len = LEN_W'(len);
        decim     = DEC_W'(dec);
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        if (len != 0) begin
            m_len   = len;
            m_decim = dec;
            m_drops = 0;
        end
    endtask

    // Rising trigger edge with a valid sample that must not be captured.
    task automatic trig_edge();
        trig      = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 14'h3FF;
        tick();
        adc_valid = 1'b0;
        m_active  = 1'b1;
        m_dec     = 0;
        m_cnt     = 0;
    endtask

    task automatic end_test(input string name);
        repeat (3) tick();
        check({name, "_state"}, 32'(state), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_extra_wr"}, 32'(extra_writes), 32'd0);
        check({name, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({name, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
    endtask

    always @(negedge clk_a) begin
        if (!rst) begin
            if (fifo_wr_en) begin
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    check("wr_data", 32'(fifo_wr_data), 32'(popped));
                end else begin
                    extra_writes++;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_with_wr", 32'(fifo_wr_en), 32'd1);
            end
        end
    end

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        adc_valid = 1'b0; fifo_full = 1'b0;
        frame_len = '0; decim = '0; adc_data = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: plain frame of 8, two surplus samples ignored
        do_arm(8, 0);
        check("t1_armed", 32'(state), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        trig_edge();
        check("t1_capture", 32'(state), 32'd2);
        for (int i = 1; i <= 10; i++) send(DATA_W'(i), 1'b0);
        end_test("t1");

        // 2: decimation by 3
        trig = 1'b0;
        do_arm(4, 2);
        trig_edge();
        for (int i = 0; i < 12; i++) send(DATA_W'(i), 1'b0);
        end_test("t2");

        // 3: fifo_full on 2nd and 3rd eligible samples
        trig = 1'b0;
        do_arm(5, 0);
        trig_edge();
        for (int i = 1; i <= 7; i++) send(DATA_W'(i), (i == 2 || i == 3));
        check("t3_drop2", 32'(drop_cnt), 32'd2);
        end_test("t3");

        // 4: trig already high at arm needs a fresh edge
        trig = 1'b1;
        tick();
        do_arm(10, 0);
        for (int i = 0; i < 4; i++) send(DATA_W'(16 + i), 1'b0);
        check("t4_still_armed", 32'(state), 32'd1);
        check("t4_no_writes", 32'(extra_writes), 32'd0);
        trig = 1'b0;
        tick();
        trig_edge();
        check("t4_capture", 32'(state), 32'd2);

        // 5: abort + arm together after 3 writes and one drop
        send(14'h021, 1'b0);
        send(14'h022, 1'b1);
        send(14'h023, 1'b0);
        send(14'h024, 1'b0);
        abort = 1'b1; arm = 1'b1; frame_len = 16'd5;
        adc_valid = 1'b1; adc_data = 14'h025;
        tick();
        abort = 1'b0; arm = 1'b0; adc_valid = 1'b0;
        m_active = 1'b0;
        check("t5_idle", 32'(state), 32'd0);
        check("t5_drop_kept", 32'(drop_cnt), 32'd1);
        send(14'h026, 1'b0);
        send(14'h027, 1'b0);
        end_test("t5");

        // 6: zero-length arm ignored; drop counter saturation
        trig = 1'b0;
        do_arm(0, 0);
        check("t6_len0_state", 32'(state), 32'd0);
        check("t6_len0_busy", 32'(busy), 32'd0);
        do_arm(1, 0);
        trig_edge();
        for (int i = 0; i < 70000; i++) send(DATA_W'(i), 1'b1);
        check("t6_drop_sat", 32'(drop_cnt), 32'h0000FFFF);
        check("t6_still_capture", 32'(state), 32'd2);
        send(14'h055, 1'b0);
        end_test("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Write-side sequencer for the dual-clock sample FIFO in the ADC capture path. Once armed, it waits for a trigger edge, then writes a programmed number of ADC samples into the FIFO, optionally decimated. It respects the FIFO full flag and counts dropped samples. It runs entirely in the FIFO write-clock domain and drives the FIFO's wr_en and wr_data directly.

Parameters:
DATA_W, 14, sample width; equals the FIFO data width.
LEN_W, 16, width of the frame length and sample counter.
DEC_W, 4, width of the decimation factor.

Ports:
clk_a  in  1  write-domain clock (FIFO write clock)
rst  in  1  synchronous, active-high reset
arm  in  1  pulse; starts a capture sequence
abort  in  1  pulse; cancels any sequence
trig  in  1  trigger level; a rising edge starts capture
frame_len  in  LEN_W  number of samples to write; latched at arm
decim  in  DEC_W  keep 1 of every decim+1 valid samples; latched at arm
adc_data  in  DATA_W  ADC sample
adc_valid  in  1  adc_data valid this cycle
fifo_full  in  1  FIFO full flag (clk_a domain)
fifo_wr_en  out  1  FIFO write strobe, registered
fifo_wr_data  out  DATA_W  FIFO write data, registered
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse at frame completion
drop_cnt  out  16  saturating count of samples lost to fifo_full
state  out  2  IDLE=0, ARMED=1, CAPTURE=2

Behaviour:
- Reset (rst=1 at a clk_a edge): state=IDLE; fifo_wr_en=0; fifo_wr_data=0; done=0; drop_cnt=0; trig_d=0; sample counter=0; decimation counter=0.
- All outputs are registered. Latency from an accepted adc_valid to fifo_wr_en is exactly 1 cycle, with fifo_wr_data equal to that cycle's adc_data.
- IDLE:
  - arm=1 and frame_len!=0 → ARMED. Latch frame_len and decim. Clear drop_cnt.
  - arm=1 with frame_len=0 is ignored; state stays IDLE.
- ARMED:
  - trig=1 and trig_d=0 (rising edge) → CAPTURE. Clear the sample and decimation counters.
  - The sample present in the edge cycle is not captured.
  - trig already high at arm time needs a fresh rising edge.
  - trig_d is registered every cycle in all states.
- CAPTURE, on each adc_valid=1:
  - Sample is eligible when dec_cnt==0.
  - dec_cnt increments per valid sample and wraps to 0 after reaching the latched decim. decim=0 means every sample is eligible.
  - Eligible and fifo_full=0: write it next cycle and increment the sample counter.
  - Eligible and fifo_full=1: drop it, no write; drop_cnt+1, saturating at 0xFFFF. Dropped samples do not count toward frame_len.
  - adc_valid=0: no counter changes.
- Completion: when the accepted sample makes the count equal the latched frame_len, the next cycle has fifo_wr_en=1 and done=1 together, and state=IDLE.
- abort=1 in any state → IDLE next cycle.
  - No done pulse is produced.
  - fifo_wr_en is 0 from the next cycle, except a write for a sample accepted in the abort cycle, which is suppressed too.
  - drop_cnt holds its value.
- Simultaneous events:
  - abort and arm in the same cycle: abort wins.
  - arm while busy is ignored.
  - Completion and abort in the same cycle: abort wins; no write, no done.
- Frame length up to 2^LEN_W−1 samples. Counters never wrap mid-frame.
- Reset mid-capture: immediate return to reset values, no done pulse.

Test Plan:
1. rst, then arm with frame_len=8 and decim=0; trig 0→1; 10 consecutive adc_valid samples 0x001..0x00A → exactly 8 writes of 0x001..0x008, done pulses with the 8th write, state=0 afterwards.
2. frame_len=4, decim=2; 12 valid samples 0..11 after the trigger edge → writes 0, 3, 6, 9; done with 9.
3. frame_len=5, decim=0; fifo_full=1 during the 2nd and 3rd eligible samples → drop_cnt=2; 5 writes total, skipping those two samples; done after the 7th valid sample.
4. trig held high before arm → stays ARMED (state=1) with no writes until trig goes 0 then 1.
5. abort mid-capture after 3 of 10 writes, with arm asserted in the same cycle → state=0 next cycle, no further wr_en, no done, drop_cnt retained.
6. arm with frame_len=0 → state stays 0, busy=0. fifo_full held 70000 samples → drop_cnt saturates at 0xFFFF.
